// File: rtl/vga_tile_scanner.sv
// VGA 640x480@60 timing generator that scans the 28x31-tile maze playfield and a
// 16x16 character sprite, producing a 2-stage registered colour-lookup bundle.
module vga_tile_scanner #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int X0     = 208,
    parameter int Y0     = 116,
    parameter logic [7:0] SPR_TRANSP = 8'hFF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_char_x,
    input  logic [7:0] i_char_y,
    output logic [9:0] o_map_addr,
    input  logic [4:0] i_map_data,
    output logic [7:0] o_sprite_addr,
    input  logic [7:0] i_sprite_data,
    output logic [1:0] o_mem_select,
    output logic [4:0] o_address_map,
    output logic [7:0] o_address_char,
    output logic [5:0] o_tile_offset,
    output logic [5:0] o_char_offset,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_blank_n,
    output logic       o_frame_start
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned POS_W   = 12;
    localparam int          H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int          V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int          FIELD_W = 224;
    localparam int          FIELD_H = 248;
    localparam int          TILES_X = 28;
    localparam int          SPR_DIM = 16;

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic [7:0]       char_x_q, char_y_q;

    // Stage 0: free-running raster counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == CNT_W'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt + CNT_W'(1);
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    // Sprite position is frozen for the whole frame at the raster origin
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            char_x_q <= '0;
            char_y_q <= '0;
        end else if (h_cnt == '0 && v_cnt == '0) begin
            char_x_q <= i_char_x;
            char_y_q <= i_char_y;
        end
    end

    logic signed [POS_W-1:0] px_c, py_c, dx_c, dy_c;
    logic                    visible_c, in_field_c, in_sprite_c;
    logic                    hsync_c, vsync_c, frame_start_c;
    logic [9:0]              map_addr_c;

    // Widened signed arithmetic so off-field positions never alias into range
    always_comb begin
        px_c          = $signed({2'b00, h_cnt}) - POS_W'(X0);
        py_c          = $signed({2'b00, v_cnt}) - POS_W'(Y0);
        dx_c          = px_c - $signed({4'b0000, char_x_q});
        dy_c          = py_c - $signed({4'b0000, char_y_q});
        visible_c     = (h_cnt < CNT_W'(H_VIS)) && (v_cnt < CNT_W'(V_VIS));
        in_field_c    = visible_c
                        && (px_c >= 0) && (px_c < POS_W'(FIELD_W))
                        && (py_c >= 0) && (py_c < POS_W'(FIELD_H));
        in_sprite_c   = in_field_c
                        && (dx_c >= 0) && (dx_c < POS_W'(SPR_DIM))
                        && (dy_c >= 0) && (dy_c < POS_W'(SPR_DIM));
        map_addr_c    = 10'(py_c[7:3]) * 10'(TILES_X) + 10'(px_c[7:3]);
        hsync_c       = !((h_cnt >= CNT_W'(H_VIS + H_FP))
                          && (h_cnt < CNT_W'(H_VIS + H_FP + H_SYNC)));
        vsync_c       = !((v_cnt >= CNT_W'(V_VIS + V_FP))
                          && (v_cnt < CNT_W'(V_VIS + V_FP + V_SYNC)));
        frame_start_c = (h_cnt == '0) && (v_cnt == '0);
    end

    logic [5:0] tile_off_s1, char_off_s1;
    logic       in_field_s1, in_sprite_s1;
    logic       hsync_s1, vsync_s1, blank_n_s1, frame_start_s1;

    // Stage 1: memory addresses plus everything carried to stage 2
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_map_addr     <= '0;
            o_sprite_addr  <= '0;
            tile_off_s1    <= '0;
            char_off_s1    <= '0;
            in_field_s1    <= 1'b0;
            in_sprite_s1   <= 1'b0;
            hsync_s1       <= 1'b1;
            vsync_s1       <= 1'b1;
            blank_n_s1     <= 1'b0;
            frame_start_s1 <= 1'b0;
        end else begin
            o_map_addr     <= in_field_c ? map_addr_c : '0;
            o_sprite_addr  <= in_sprite_c ? {dy_c[3:0], dx_c[3:0]} : '0;
            tile_off_s1    <= in_field_c ? {py_c[2:0], px_c[2:0]} : '0;
            char_off_s1    <= in_sprite_c ? {dy_c[2:0], dx_c[2:0]} : '0;
            in_field_s1    <= in_field_c;
            in_sprite_s1   <= in_sprite_c;
            hsync_s1       <= hsync_c;
            vsync_s1       <= vsync_c;
            blank_n_s1     <= visible_c;
            frame_start_s1 <= frame_start_c;
        end
    end

    logic [1:0] mem_select_c;

    // Opaque sprite pixels win over the maze; transparent ones fall through
    always_comb begin
        mem_select_c = 2'b00;
        if (in_sprite_s1 && i_sprite_data != SPR_TRANSP) begin
            mem_select_c = 2'b11;
        end else if (in_field_s1) begin
            mem_select_c = 2'b01;
        end
    end

    // Stage 2: registered output bundle with matching sync delay
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_mem_select   <= 2'b00;
            o_address_map  <= '0;
            o_address_char <= '0;
            o_tile_offset  <= '0;
            o_char_offset  <= '0;
            o_hsync        <= 1'b1;
            o_vsync        <= 1'b1;
            o_blank_n      <= 1'b0;
            o_frame_start  <= 1'b0;
        end else begin
            o_mem_select   <= mem_select_c;
            o_address_map  <= in_field_s1 ? i_map_data : '0;
            o_address_char <= in_field_s1 ? i_sprite_data : '0;
            o_tile_offset  <= tile_off_s1;
            o_char_offset  <= char_off_s1;
            o_hsync        <= hsync_s1;
            o_vsync        <= vsync_s1;
            o_blank_n      <= blank_n_s1;
            o_frame_start  <= frame_start_s1;
        end
    end

endmodule
